// File: rtl/signed_divider_if.sv
// Handshake and data bundle for signed_divider.
// Requester drives start/operands; divider returns status and results.
interface signed_divider_if #(
  parameter int BIT_WIDTH    = 16,
  parameter int RESULT_WIDTH = 32
);
  logic                    start;
  logic [RESULT_WIDTH-1:0] dividend;
  logic [BIT_WIDTH-1:0]    divisor;
  logic                    busy;
  logic                    done;
  logic [RESULT_WIDTH-1:0] quotient;
  logic [BIT_WIDTH-1:0]    remainder;
  logic                    div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/signed_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per cycle.
// Optional divide-by-zero short path: define DIV_BY_ZERO_CHECK_EN.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 32
`endif

module signed_divider #(
  parameter int BIT_WIDTH    = `BIT_WIDTH,
  parameter int RESULT_WIDTH = `RESULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  signed_divider_if.slave s
);
  localparam int BW = BIT_WIDTH;
  localparam int RW = RESULT_WIDTH;
  localparam int CW = $clog2(RW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t        state, nxt;
  logic [BW:0]   pr;
  logic [RW-1:0] qm;
  logic [BW-1:0] dm;
  logic [CW-1:0] cnt;
  logic          sq, sr, dz_pend;
  logic          done_q, dz_q, busy_c;
  logic [RW-1:0] q_q;
  logic [BW-1:0] r_q;

  logic          accept, last, zero_div;
  logic [RW-1:0] dvd_mag;
  logic [BW-1:0] dvs_mag;
  logic [BW:0]   sh;
  logic [BW+1:0] diff;

  assign accept  = (state == IDLE) && s.start;
  assign last    = (cnt == CW'(RW - 1));
  assign dvd_mag = s.dividend[RW-1] ? -s.dividend : s.dividend;
  assign dvs_mag = s.divisor[BW-1] ? -s.divisor : s.divisor;
  assign sh      = {pr[BW-1:0], qm[RW-1]};
  assign diff    = {1'b0, sh} - {2'b00, dm};

`ifdef DIV_BY_ZERO_CHECK_EN
  assign zero_div = (s.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (s.start) nxt = zero_div ? SIGN : CALC;
      CALC:    if (last) nxt = SIGN;
      SIGN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // status output decode
  always_comb begin
    busy_c = 1'b0;
    unique case (1'b1)
      (state == CALC): busy_c = 1'b1;
      (state == SIGN): busy_c = 1'b1;
      default:         busy_c = 1'b0;
    endcase
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr      <= '0;
      qm      <= '0;
      dm      <= '0;
      cnt     <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      dz_pend <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        pr      <= '0;
        qm      <= dvd_mag;
        dm      <= dvs_mag;
        sq      <= s.dividend[RW-1] ^ s.divisor[BW-1];
        sr      <= s.dividend[RW-1];
        cnt     <= '0;
        dz_pend <= zero_div;
        dz_q    <= 1'b0;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (!diff[BW+1]) begin
          pr <= diff[BW:0];
          qm <= {qm[RW-2:0], 1'b1};
        end else begin
          pr <= sh;
          qm <= {qm[RW-2:0], 1'b0};
        end
      end else if (state == SIGN) begin
        done_q <= 1'b1;
        if (dz_pend) begin
          q_q  <= '1;
          r_q  <= '0;
          dz_q <= 1'b1;
        end else begin
          q_q <= sq ? -qm : qm;
          r_q <= sr ? -pr[BW-1:0] : pr[BW-1:0];
        end
      end
    end
  end

  assign s.busy        = busy_c;
  assign s.done        = done_q;
  assign s.quotient    = q_q;
  assign s.remainder   = r_q;
  assign s.div_by_zero = dz_q;
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default `BIT_WIDTH (16): divisor and remainder width.
REQ-002 SHALL have parameter RESULT_WIDTH, default `RESULT_WIDTH (32): dividend and quotient width; RESULT_WIDTH > BIT_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request; operands sampled when start=1 and busy=0.
REQ-006 SHALL have port dividend  input  RESULT_WIDTH  signed two's-complement dividend.
REQ-007 SHALL have port divisor  input  BIT_WIDTH  signed two's-complement divisor.
REQ-008 SHALL have port busy  output  1  high while an accepted division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 SHALL have port quotient  output  RESULT_WIDTH  signed quotient, held until next accepted start.
REQ-011 SHALL have port remainder  output  BIT_WIDTH  signed remainder, held until next accepted start.
REQ-012 SHALL have port div_by_zero  output  1  divide-by-zero flag, held with results.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, SIGN; IDLE->CALC on accepted start, CALC->SIGN after RESULT_WIDTH iterations, SIGN->IDLE unconditionally.
REQ-014 SHALL, on accepted start (edge N), register |dividend|, |divisor| as unsigned magnitudes, sign_q = dividend MSB XOR divisor MSB, sign_r = dividend MSB, clear iteration counter.
REQ-015 SHALL in CALC perform one restoring-division step per cycle, MSB first: shift partial remainder left one bit bringing in next dividend magnitude bit, subtract divisor magnitude if result non-negative, shift in quotient bit 1 else 0.
REQ-016 SHALL use a partial remainder of BIT_WIDTH+1 bits so the trial subtraction never overflows.
REQ-017 SHALL in SIGN write quotient = sign_q ? -Qmag : Qmag and remainder = sign_r ? -Rmag : Rmag (truncating division, remainder takes dividend's sign), and assert done.
REQ-018 SHALL produce done at edge N+RESULT_WIDTH+1 (33 cycles for default); busy high from edge N through edge N+RESULT_WIDTH+1 exclusive.
REQ-019 SHALL ignore start while busy=1; operands changing during busy SHALL not affect the result.
REQ-020 SHALL accept a start presented in the same cycle done is high (back-to-back operation).
REQ-021 SHALL treat magnitude of most-negative dividend (0x80000000) as unsigned 2^31; most-negative / -1 SHALL yield quotient 0x80000000 (wrap), remainder 0.
REQ-022 SHALL keep quotient, remainder, div_by_zero stable between done pulses; div_by_zero cleared on each accepted start.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, enter IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-024 SHALL abort any in-progress division on reset without producing done; first start after reset release SHALL be accepted.

Configuration
REQ-025 SHALL compile divide-by-zero detection in when macro DIV_BY_ZERO_CHECK_EN is defined.
REQ-026 SHALL, with DIV_BY_ZERO_CHECK_EN defined, on accepted start with divisor=0 skip CALC, and at edge N+1 set quotient all ones, remainder 0, div_by_zero=1, done=1.
REQ-027 SHALL, without DIV_BY_ZERO_CHECK_EN, tie div_by_zero to 0 and run divisor=0 through the normal 33-cycle path; result content is not specified.

Verification
REQ-028 SHALL test dividend 100, divisor 7 -> quotient 14, remainder 2, done exactly 33 cycles after start edge.
REQ-029 SHALL test -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFE; 100/-7 -> 0xFFFFFFF2, 0x0002; -100/-7 -> 0x0000000E, 0xFFFE.
REQ-030 SHALL test 0x80000000 / 0xFFFF -> quotient 0x80000000, remainder 0; 0x7FFFFFFF / 0x7FFF -> quotient 0x00010002, remainder 0x0001.
REQ-031 SHALL test, with DIV_BY_ZERO_CHECK_EN, 55/0 -> quotient 0xFFFFFFFF, remainder 0, div_by_zero=1, done 1 cycle after start; next 10/3 clears flag, yields 3 rem 1.
REQ-032 SHALL test start re-asserted with new operands at cycle 10 of busy -> ignored, original result delivered at cycle 33; start on done cycle -> second result 33 cycles later.
REQ-033 SHALL test rst_n low at cycle 20 of busy -> next edge busy=0, done=0, outputs 0, no done pulse afterwards.
